alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; power of two, >=8.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(DATA_WIDTH), shift-amount width.
REQ-003 clk_in  input  1  single clock, all state on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 op_valid_in  input  1  request valid.
REQ-006 op_ready_out  output  1  controller can accept request.
REQ-007 uop_in  input  4  micro-opcode, ALU encoding (0000 ADD ... 1101 SRA, 1110 SRL, 1111 SLL).
REQ-008 a_data_in / b_data_in  input  DATA_WIDTH  operands RS1 / RS2.
REQ-009 flush_in  input  1  abort in-flight operation.
REQ-010 alu_a_out / alu_b_out  output  DATA_WIDTH  operands driven to external ALU.
REQ-011 alu_uop_out  output  4  uop driven to external ALU.
REQ-012 alu_result_in  input  DATA_WIDTH  combinational ALU result.
REQ-013 result_out  output  DATA_WIDTH  registered result.
REQ-014 result_valid_out / result_ready_in  output / input  1  result handshake.
REQ-015 illegal_out  output  1  qualifies result_out; uop was reserved (0101, 0110, 0111, 1100).

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, SHIFT, DONE.
REQ-017 op_ready_out SHALL be 1 only in IDLE; accept = op_valid_in & op_ready_out.
REQ-018 On accept SHALL register uop, a, b; shifts (1101/1110/1111) -> SHIFT with cnt = b[SHAMT_W-1:0]; all others -> EXEC.
REQ-019 EXEC SHALL drive registered operands/uop onto alu_*_out, capture alu_result_in into result_out, go DONE; accept at T -> result_valid_out at T+2.
REQ-020 Reserved uop in EXEC SHALL capture result 0, set illegal_out=1, not drive uop to ALU (alu_uop_out=0000).
REQ-021 SHIFT SHALL shift internal register 1 bit/cycle (SLL: 0 in at LSB; SRL: 0 in at MSB; SRA: sign in at MSB) and decrement cnt while cnt!=0; at cnt==0 copy register to result_out, go DONE; result_valid_out at T+2+shamt.
REQ-022 Upper b bits beyond SHAMT_W SHALL be ignored; shamt=0 SHALL return a unchanged at T+2.
REQ-023 DONE SHALL hold result_valid_out=1 and result_out/illegal_out stable until result_ready_in=1, then IDLE; no accept in same cycle (max throughput 1 op / 3 cycles).
REQ-024 flush_in=1 SHALL force IDLE next cycle from any state, discard result, clear result_valid_out; flush beats accept in same cycle (request not taken, op_ready_out still high).
REQ-025 alu_*_out SHALL be 0 outside EXEC.

Reset
REQ-026 rst_n_in=0 SHALL immediately force IDLE, cnt=0, result_out=0, result_valid_out=0, illegal_out=0, operand registers 0; mid-operation reset drops work silently.
REQ-027 op_ready_out SHALL be 1 from first clock after reset release.

Configuration
REQ-028 Macro ALU_SEQ_FAST_SHIFT_EN defined: shifts SHALL route through EXEC to external ALU, fixed latency T+2, SHIFT state and iterative shifter not instantiated.
REQ-029 Macro undefined: REQ-021 iterative path used; ALU SHALL never see uops 1101-1111.

Structure
REQ-030 Shared package alu_seq_pkg SHALL hold uop localparams (UOP_ADD ... UOP_SLL), reserved-uop decode function, FSM state encoding.
REQ-031 Iterative shifter (register, cnt, direction/fill) SHALL be sub-module alu_iter_shifter, omitted under ALU_SEQ_FAST_SHIFT_EN.

Verification
REQ-032 ADD a=0x00000005 b=0x00000003, model ALU returns 0x8 -> result_out=0x00000008, valid at T+2, illegal_out=0.
REQ-033 SRA a=0x80000000 b=0x00000024 (shamt 4) -> result_out=0xF8000000 at T+6 (fast: T+2, ALU uop 1101).
REQ-034 uop 1100 a=0x1 b=0x1 -> illegal_out=1, result_out=0, alu_uop_out stays 0000.
REQ-035 SLL shamt=31, result_ready_in held 0 for 5 cycles after valid -> result_out stable, op_ready_out=0 until handshake.
REQ-036 flush_in during SHIFT cycle 3 of SRL shamt=10 -> IDLE next cycle, no result_valid_out; flush+op_valid same cycle -> request not accepted.
REQ-037 rst_n_in low asynchronously mid-SHIFT -> all outputs 0 before next edge, op_ready_out=1 after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequenced ALU controller: micro-opcodes, FSM
// encoding and opcode decode helpers.
package alu_seq_pkg;

    localparam logic [3:0] UOP_ADD   = 4'b0000;
    localparam logic [3:0] UOP_SUB   = 4'b0001;
    localparam logic [3:0] UOP_AND   = 4'b0010;
    localparam logic [3:0] UOP_OR    = 4'b0011;
    localparam logic [3:0] UOP_XOR   = 4'b0100;
    localparam logic [3:0] UOP_SLT   = 4'b1000;
    localparam logic [3:0] UOP_SLTU  = 4'b1001;
    localparam logic [3:0] UOP_NOR   = 4'b1010;
    localparam logic [3:0] UOP_PASSB = 4'b1011;
    localparam logic [3:0] UOP_SRA   = 4'b1101;
    localparam logic [3:0] UOP_SRL   = 4'b1110;
    localparam logic [3:0] UOP_SLL   = 4'b1111;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef enum logic [1:0] {
        SHK_NONE = 2'b00,
        SHK_SRA  = 2'b01,
        SHK_SRL  = 2'b10,
        SHK_SLL  = 2'b11
    } shift_kind_e;

    function automatic logic uop_is_reserved(input logic [3:0] uop);
        logic rsv;
        case (uop)
            4'b0101, 4'b0110, 4'b0111, 4'b1100: rsv = 1'b1;
            default:                            rsv = 1'b0;
        endcase
        return rsv;
    endfunction

    function automatic logic uop_is_shift(input logic [3:0] uop);
        return (uop == UOP_SRA) || (uop == UOP_SRL) || (uop == UOP_SLL);
    endfunction

    function automatic shift_kind_e uop_shift_kind(input logic [3:0] uop);
        shift_kind_e kind;
        case (uop)
            UOP_SRA: kind = SHK_SRA;
            UOP_SRL: kind = SHK_SRL;
            UOP_SLL: kind = SHK_SLL;
            default: kind = SHK_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_shifter.sv
// Iterative one-bit-per-cycle shifter used by alu_seq_ctrl when shifts are
// not routed to the external ALU (left out when ALU_SEQ_FAST_SHIFT_EN is set).
module alu_iter_shifter
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [SHAMT_W-1:0]    load_shamt,
    input  shift_kind_e           load_kind,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  cnt_zero
);

    logic [DATA_WIDTH-1:0] sh_reg;
    logic [SHAMT_W-1:0]    cnt;
    shift_kind_e           kind;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sh_reg <= '0;
            cnt    <= '0;
            kind   <= SHK_NONE;
        end else if (load) begin
            sh_reg <= load_data;
            cnt    <= load_shamt;
            kind   <= load_kind;
        end else if (step && (cnt != '0)) begin
            case (kind)
                SHK_SLL: sh_reg <= {sh_reg[DATA_WIDTH-2:0], 1'b0};
                SHK_SRL: sh_reg <= {1'b0, sh_reg[DATA_WIDTH-1:1]};
                SHK_SRA: sh_reg <= {sh_reg[DATA_WIDTH-1], sh_reg[DATA_WIDTH-1:1]};
                default: sh_reg <= sh_reg;
            endcase
            cnt <= cnt - SHAMT_W'(1);
        end
    end

    assign data     = sh_reg;
    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request/result sequencer in front of an external combinational ALU.
// ALU_SEQ_FAST_SHIFT_EN: shifts go to the external ALU instead of the iterative shifter.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | operands on the ALU bus, result captured at end of cycle
// SHIFT | iterative shift in progress, one bit per cycle
// DONE  | result presented, waiting for result_ready_in
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  op_valid_in,
    output logic                  op_ready_out,
    input  logic [3:0]            uop_in,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    input  logic                  flush_in,
    output logic [DATA_WIDTH-1:0] alu_a_out,
    output logic [DATA_WIDTH-1:0] alu_b_out,
    output logic [3:0]            alu_uop_out,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  result_valid_out,
    input  logic                  result_ready_in,
    output logic                  illegal_out
);

    logic [1:0]            state;
    logic [1:0]            nxt;
    logic                  rst_done;
    logic                  accept;
    logic                  go_shift;
    logic                  in_exec;
    logic                  exec_rsv;
    logic [3:0]            uop_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] sh_data;
    logic                  sh_zero;

    // Held low through reset so the request port only opens after the first clock.
    assign op_ready_out = rst_done && (state == ST_IDLE);
    assign accept       = op_valid_in && op_ready_out && !flush_in;

`ifdef ALU_SEQ_FAST_SHIFT_EN
    assign go_shift = 1'b0;
    assign sh_data  = '0;
    assign sh_zero  = 1'b1;
`else
    assign go_shift = uop_is_shift(uop_in);

    alu_iter_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W)
    ) u_shifter (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load       (accept && go_shift),
        .load_data  (a_data_in),
        .load_shamt (b_data_in[SHAMT_W-1:0]),
        .load_kind  (uop_shift_kind(uop_in)),
        .step       (state == ST_SHIFT),
        .data       (sh_data),
        .cnt_zero   (sh_zero)
    );
`endif

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (accept) nxt = go_shift ? ST_SHIFT : ST_EXEC;
            ST_EXEC:  nxt = ST_DONE;
            ST_SHIFT: if (sh_zero) nxt = ST_DONE;
            ST_DONE:  if (result_ready_in) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        if (flush_in) nxt = ST_IDLE;
    end

    assign in_exec  = (state == ST_EXEC);
    assign exec_rsv = uop_is_reserved(uop_q);

    // Reserved opcodes never reach the ALU; it sees ADD-encoding 0000 instead.
    assign alu_a_out        = in_exec ? a_q : '0;
    assign alu_b_out        = in_exec ? b_q : '0;
    assign alu_uop_out      = (in_exec && !exec_rsv) ? uop_q : 4'b0000;
    assign result_valid_out = (state == ST_DONE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ST_IDLE;
            rst_done    <= 1'b0;
            uop_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_out  <= '0;
            illegal_out <= 1'b0;
        end else begin
            state    <= nxt;
            rst_done <= 1'b1;
            if (accept) begin
                uop_q <= uop_in;
                a_q   <= a_data_in;
                b_q   <= b_data_in;
            end
            if (!flush_in) begin
                case (state)
                    ST_EXEC: begin
                        result_out  <= exec_rsv ? '0 : alu_result_in;
                        illegal_out <= exec_rsv;
                    end
                    ST_SHIFT: begin
                        if (sh_zero) begin
                            result_out  <= sh_data;
                            illegal_out <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: randomized ops against a behavioural model,
// plus directed reset, stall, flush and shift-boundary cases (ALU_SEQ_FAST_SHIFT_EN aware).
module tb_alu_seq_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        op_valid_in;
    logic        op_ready_out;
    logic [3:0]  uop_in;
    logic [31:0] a_data_in;
    logic [31:0] b_data_in;
    logic        flush_in;
    logic [31:0] alu_a_out;
    logic [31:0] alu_b_out;
    logic [3:0]  alu_uop_out;
    logic [31:0] alu_result_in;
    logic [31:0] result_out;
    logic        result_valid_out;
    logic        result_ready_in;
    logic        illegal_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bp_mode  = 0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_seq_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .op_valid_in      (op_valid_in),
        .op_ready_out     (op_ready_out),
        .uop_in           (uop_in),
        .a_data_in        (a_data_in),
        .b_data_in        (b_data_in),
        .flush_in         (flush_in),
        .alu_a_out        (alu_a_out),
        .alu_b_out        (alu_b_out),
        .alu_uop_out      (alu_uop_out),
        .alu_result_in    (alu_result_in),
        .result_out       (result_out),
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready_in),
        .illegal_out      (illegal_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic is_rsv(input logic [3:0] u);
        return (u == 4'd5) || (u == 4'd6) || (u == 4'd7) || (u == 4'd12);
    endfunction

    function automatic logic is_shift(input logic [3:0] u);
        return u >= 4'd13;
    endfunction

    // Behaviour of the whole operation set in plain arithmetic.
    function automatic logic [31:0] op_model(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (u)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd8:    r = {31'd0, $signed(a) < $signed(b)};
            4'd9:    r = {31'd0, a < b};
            4'd10:   r = ~(a | b);
            4'd11:   r = b;
            4'd13:   r = $signed(a) >>> b[4:0];
            4'd14:   r = a >> b[4:0];
            4'd15:   r = a << b[4:0];
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    assign alu_result_in = op_model(alu_uop_out, alu_a_out, alu_b_out);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cyc %0d", nm, act, req, cyc);
        end
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                prev = 1'b0;
            end else begin
                if (alu_uop_out != 4'd0) begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                    chk("alu_uop_not_reserved", {31'd0, is_rsv(alu_uop_out)}, 32'd0);
`else
                    chk("alu_uop_not_reserved_or_shift", {31'd0, is_rsv(alu_uop_out) | is_shift(alu_uop_out)}, 32'd0);
`endif
                end
                if (op_ready_out || result_valid_out)
                    chk("alu_bus_zero_outside_exec", alu_a_out | alu_b_out | {28'd0, alu_uop_out}, 32'd0);
                if (result_valid_out && !prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid actual=1 required=0 result=%h at cyc %0d", result_out, cyc);
                    end else begin
                        chk("latency", cyc - sb[0].acc, sb[0].lat);
                        chk("result_at_valid", result_out, sb[0].res);
                    end
                end
                if (result_valid_out && result_ready_in && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("result_at_handshake", result_out, e.res);
                    chk("illegal_at_handshake", {31'd0, illegal_out}, {31'd0, e.ill});
                end
                prev = result_valid_out;
            end
        end
    end

    initial begin : ready_driver
        result_ready_in = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            case (bp_mode)
                0:       result_ready_in = 1'b1;
                1:       result_ready_in = ($urandom_range(0, 3) != 0);
                default: result_ready_in = 1'b0;
            endcase
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_accept(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                                output int acc, output bit ok);
        uop_in      = u;
        a_data_in   = a;
        b_data_in   = b;
        op_valid_in = 1'b1;
        ok  = 1'b0;
        acc = 0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clk_in);
            if (op_ready_out) begin
                acc = cyc + 1;
                ok  = 1'b1;
            end
            @(posedge clk_in);
            #1;
        end
        op_valid_in = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_ready required=ready uop=%h", u);
        end
    endtask

    task automatic issue(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b);
        int   acc;
        bit   ok;
        exp_t e;
        drive_accept(u, a, b, acc, ok);
        if (ok) begin
            e.res = is_rsv(u) ? 32'd0 : op_model(u, a, b);
            e.ill = is_rsv(u);
            e.acc = acc;
`ifdef ALU_SEQ_FAST_SHIFT_EN
            e.lat = 1;
`else
            e.lat = is_shift(u) ? 1 + int'(b[4:0]) : 1;
`endif
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 3000 && sb.size() > 0; w++) @(posedge clk_in);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_op_ready"}, {31'd0, op_ready_out}, 32'd0);
        chk({nm, "_result_valid"}, {31'd0, result_valid_out}, 32'd0);
        chk({nm, "_result"}, result_out, 32'd0);
        chk({nm, "_illegal"}, {31'd0, illegal_out}, 32'd0);
        chk({nm, "_alu_bus"}, alu_a_out | alu_b_out | {28'd0, alu_uop_out}, 32'd0);
    endtask

    initial begin : main
        int          acc;
        bit          ok;
        bit          seen;
        logic [3:0]  u;
        logic [31:0] a;
        logic [31:0] b;

        rst_n_in    = 1'b0;
        op_valid_in = 1'b0;
        uop_in      = 4'd0;
        a_data_in   = 32'd0;
        b_data_in   = 32'd0;
        flush_in    = 1'b0;

        repeat (3) @(posedge clk_in);
        #1;
        chk_all_zero("reset_state");
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("ready_after_reset", {31'd0, op_ready_out}, 32'd1);

        issue(4'd0, 32'h0000_0005, 32'h0000_0003);
        issue(4'd13, 32'h8000_0000, 32'h0000_0024);
        issue(4'd12, 32'h0000_0001, 32'h0000_0001);
        issue(4'd14, 32'hA5A5_0F0F, 32'hFFFF_FFE0);
        issue(4'd15, 32'h0000_0001, 32'h0000_0000);
        wait_drain();

        // Result must stay put while the consumer stalls.
        bp_mode = 2;
        issue(4'd15, 32'h1234_5679, 32'd31);
        seen = 1'b0;
        for (int w = 0; w < 100 && !seen; w++) begin
            @(negedge clk_in);
            seen = result_valid_out;
        end
        chk("stall_valid_seen", {31'd0, seen}, 32'd1);
        repeat (5) begin
            @(negedge clk_in);
            chk("stall_op_ready_low", {31'd0, op_ready_out}, 32'd0);
            chk("stall_result_stable", result_out, 32'h8000_0000);
            chk("stall_valid_held", {31'd0, result_valid_out}, 32'd1);
        end
        @(posedge clk_in);
        #1;
        bp_mode = 0;
        wait_drain();

        // Flush on the third SHIFT cycle of SRL by 10, with a request also raised.
        drive_accept(4'd14, 32'hF000_0000, 32'd10, acc, ok);
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        flush_in    = 1'b1;
        op_valid_in = 1'b1;
        uop_in      = 4'd0;
        @(posedge clk_in);
        #1;
        flush_in    = 1'b0;
        op_valid_in = 1'b0;
        @(negedge clk_in);
        chk("flush_to_idle", {31'd0, op_ready_out}, 32'd1);
        chk("flush_no_valid", {31'd0, result_valid_out}, 32'd0);
        repeat (20) @(posedge clk_in);
        #1;

        // Flush wins over a simultaneous accept in IDLE.
        flush_in    = 1'b1;
        op_valid_in = 1'b1;
        uop_in      = 4'd0;
        a_data_in   = 32'd1;
        b_data_in   = 32'd1;
        @(negedge clk_in);
        chk("flush_ready_still_high", {31'd0, op_ready_out}, 32'd1);
        @(posedge clk_in);
        #1;
        flush_in    = 1'b0;
        op_valid_in = 1'b0;
        @(negedge clk_in);
        chk("flush_beats_accept", {31'd0, op_ready_out}, 32'd1);
        repeat (5) @(posedge clk_in);
        #1;

        // Asynchronous reset in the middle of a long shift.
        drive_accept(4'd15, $urandom, 32'd31, acc, ok);
        repeat (3) @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("ready_after_midop_reset", {31'd0, op_ready_out}, 32'd1);

        bp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            u = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (is_shift(u) && $urandom_range(0, 3) == 0)
                b = (b & 32'hFFFF_FFE0) | 32'($urandom_range(0, 2));
            issue(u, a, b);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
